// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a req/gnt + rvalid data bus, aligns load data, stalls the pipe while busy.
// Optional bus-wait timeout is compiled in with MEM_TIMEOUT_EN (TIMEOUT_CYCLES sets the limit).
//
// state | meaning
// IDLE  | no access outstanding; accepts a new instruction each cycle
// REQ   | bus request asserted, waiting for dbus_gnt
// RESP  | request granted, waiting for dbus_rvalid
module mem_access_unit
`ifdef MEM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  mem_aluop,
    input  logic [4:0]  mem_wa,
    input  logic [31:0] mem_wd,
    input  logic        mem_wreg,
    input  logic        mem_mreg,
    input  logic [31:0] mem_din,
    output logic        stall_req,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_wa,
    output logic [31:0] wb_wd,
    output logic        wb_wreg,
    output logic        addr_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] OP_LB  = 8'h90;
    localparam logic [7:0] OP_LBU = 8'h91;
    localparam logic [7:0] OP_LH  = 8'h92;
    localparam logic [7:0] OP_LHU = 8'h93;
    localparam logic [7:0] OP_LW  = 8'h94;
    localparam logic [7:0] OP_SB  = 8'h98;
    localparam logic [7:0] OP_SH  = 8'h99;
    localparam logic [7:0] OP_SW  = 8'h9A;

    state_t      state, state_nxt;
    logic [7:0]  op_q;
    logic [4:0]  wa_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;

    logic        is_mem, is_store, misaligned;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic        accept, timeout;

    logic        wb_valid_nxt, wb_wreg_nxt, addr_err_nxt;
    logic [4:0]  wb_wa_nxt;
    logic [31:0] wb_wd_nxt;
    logic [31:0] shifted, load_data;

    // Decode of the incoming instruction; unknown codes with mem_mreg=1 fall through as non-memory.
    always_comb begin
        is_mem     = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        be_in      = 4'h0;
        wdata_in   = mem_din;
        if (mem_mreg) begin
            case (mem_aluop)
                OP_LB, OP_LBU, OP_SB: begin
                    is_mem   = 1'b1;
                    be_in    = 4'b0001 << mem_wd[1:0];
                    wdata_in = {4{mem_din[7:0]}};
                end
                OP_LH, OP_LHU, OP_SH: begin
                    is_mem     = 1'b1;
                    be_in      = 4'b0011 << mem_wd[1:0];
                    wdata_in   = {2{mem_din[15:0]}};
                    misaligned = mem_wd[0];
                end
                OP_LW, OP_SW: begin
                    is_mem     = 1'b1;
                    be_in      = 4'hF;
                    misaligned = |mem_wd[1:0];
                end
                default: ;
            endcase
            is_store = is_mem && (mem_aluop == OP_SB || mem_aluop == OP_SH || mem_aluop == OP_SW);
        end
    end

    always_comb begin
        shifted   = dbus_rdata >> {addr_q[1:0], 3'b000};
        load_data = shifted;
        case (op_q)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'h0, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Down-counter reloads on entering REQ and on gnt; terminal count is reached in the
    // TIMEOUT_CYCLES-th wait cycle of the current phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (accept || (state == REQ && dbus_gnt))
            wait_cnt <= CNT_LOAD;
        else if (state != IDLE && wait_cnt != '0)
            wait_cnt <= wait_cnt - 1'b1;
    end

    assign timeout = (wait_cnt == '0) &&
                     ((state == REQ && !dbus_gnt) || (state == RESP && !dbus_rvalid));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        stall_req    = 1'b0;
        accept       = 1'b0;
        wb_valid_nxt = 1'b0;
        wb_wa_nxt    = 5'h0;
        wb_wd_nxt    = 32'h0;
        wb_wreg_nxt  = 1'b0;
        addr_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_nxt = 1'b1;
                        wb_wa_nxt    = mem_wa;
                        wb_wd_nxt    = mem_wd;
                        wb_wreg_nxt  = mem_wreg;
                    end else if (misaligned) begin
                        wb_valid_nxt = 1'b1;
                        wb_wa_nxt    = mem_wa;
                        addr_err_nxt = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        stall_req = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (timeout) begin
                    state_nxt    = IDLE;
                    wb_valid_nxt = 1'b1;
                    wb_wa_nxt    = wa_q;
                    addr_err_nxt = 1'b1;
                end else begin
                    stall_req = 1'b1;
                    if (dbus_gnt)
                        state_nxt = RESP;
                end
            end
            RESP: begin
                if (dbus_rvalid) begin
                    state_nxt    = IDLE;
                    wb_valid_nxt = 1'b1;
                    wb_wa_nxt    = wa_q;
                    wb_wreg_nxt  = !we_q;
                    wb_wd_nxt    = we_q ? 32'h0 : load_data;
                end else if (timeout) begin
                    state_nxt    = IDLE;
                    wb_valid_nxt = 1'b1;
                    wb_wa_nxt    = wa_q;
                    addr_err_nxt = 1'b1;
                end else begin
                    stall_req = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 8'h0;
            wa_q    <= 5'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            we_q    <= 1'b0;
        end else if (accept) begin
            op_q    <= mem_aluop;
            wa_q    <= mem_wa;
            addr_q  <= mem_wd;
            wdata_q <= wdata_in;
            be_q    <= be_in;
            we_q    <= is_store;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_wa    <= 5'h0;
            wb_wd    <= 32'h0;
            wb_wreg  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            wb_valid <= wb_valid_nxt;
            wb_wa    <= wb_wa_nxt;
            wb_wd    <= wb_wd_nxt;
            wb_wreg  <= wb_wreg_nxt;
            addr_err <= addr_err_nxt;
        end
    end

    // Bus attributes come straight from the latched op, so they cannot move while waiting for gnt.
    assign dbus_req   = (state == REQ);
    assign dbus_we    = dbus_req & we_q;
    assign dbus_addr  = dbus_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dbus_be    = dbus_req ? be_q : 4'h0;
    assign dbus_wdata = dbus_req ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized ops against a reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  mem_aluop = 8'h0;
    logic [4:0]  mem_wa = 5'h0;
    logic [31:0] mem_wd = 32'h0;
    logic        mem_wreg = 1'b0;
    logic        mem_mreg = 1'b0;
    logic [31:0] mem_din = 32'h0;
    logic        stall_req, dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt = 1'b0;
    logic        dbus_rvalid = 1'b0;
    logic [31:0] dbus_rdata = 32'h0;
    logic        wb_valid, wb_wreg, addr_err;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;

    int n_assert = 0;
    int n_fail   = 0;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .mem_aluop(mem_aluop), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .mem_wreg(mem_wreg), .mem_mreg(mem_mreg), .mem_din(mem_din),
        .stall_req(stall_req), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .wb_valid(wb_valid), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .wb_wreg(wb_wreg), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    // Reference model: access size in bytes, 0 for anything that is not a memory op.
    function automatic int ref_size(input logic [7:0] op, input logic mreg);
        if (!mreg) return 0;
        case (op)
            8'h90, 8'h91, 8'h98: return 1;
            8'h92, 8'h93, 8'h99: return 2;
            8'h94, 8'h9A:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit ref_store(input logic [7:0] op);
        return (op == 8'h98) || (op == 8'h99) || (op == 8'h9A);
    endfunction

    function automatic bit ref_signed(input logic [7:0] op);
        return (op == 8'h90) || (op == 8'h92);
    endfunction

    function automatic logic [3:0] ref_be(input int sz, input logic [31:0] addr);
        int b;
        b = ((1 << sz) - 1) << (addr % 4);
        return b[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] din);
        if (sz == 1) return {24'h0, din[7:0]} * 32'h01010101;
        if (sz == 2) return {16'h0, din[15:0]} * 32'h00010001;
        return din;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int          sz;
        logic [63:0] v, mask;
        sz   = ref_size(op, 1'b1);
        v    = {32'h0, rdata} >> (8 * (addr % 4));
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = v & mask;
        if (ref_signed(op) && v >= (64'd1 << (8 * sz - 1)))
            v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk1 ({tag, "_stall"},    stall_req,  1'b0);
        chk1 ({tag, "_req"},      dbus_req,   1'b0);
        chk1 ({tag, "_we"},       dbus_we,    1'b0);
        chk32({tag, "_addr"},     dbus_addr,  32'h0);
        chk32({tag, "_be"},       {28'h0, dbus_be}, 32'h0);
        chk32({tag, "_wdata"},    dbus_wdata, 32'h0);
        chk1 ({tag, "_wb_valid"}, wb_valid,   1'b0);
        chk32({tag, "_wb_wa"},    {27'h0, wb_wa}, 32'h0);
        chk32({tag, "_wb_wd"},    wb_wd,      32'h0);
        chk1 ({tag, "_wb_wreg"},  wb_wreg,    1'b0);
        chk1 ({tag, "_addr_err"}, addr_err,   1'b0);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        #1;
        chk1("idle_wb_valid", wb_valid, 1'b0);
        chk1("idle_addr_err", addr_err, 1'b0);
        chk1("idle_req",      dbus_req, 1'b0);
        chk1("idle_stall",    stall_req, 1'b0);
    endtask

    // Issues one instruction at the current (post-negedge) time and follows it to its writeback cycle.
    // gd = wait cycles before gnt, rd = wait cycles in RESP before rvalid.
    task automatic do_op(input logic [7:0] op, input logic mreg, input logic wreg,
                         input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] din,
                         input int gd, input int rd, input logic [31:0] rdata);
        int sz;
        bit mis, st;
        sz  = ref_size(op, mreg);
        mis = (sz != 0) && ((wd % sz) != 0);
        st  = ref_store(op);
        in_valid = 1'b1; mem_aluop = op; mem_mreg = mreg; mem_wreg = wreg;
        mem_wa = wa; mem_wd = wd; mem_din = din;
        #1;
        chk1("accept_stall", stall_req, (sz != 0) && !mis);
        chk1("accept_req",   dbus_req, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; mem_wd = $urandom; mem_din = $urandom; mem_wa = 5'($urandom);
        if (sz == 0 || mis) begin
            #1;
            chk1 ("direct_wb_valid", wb_valid, 1'b1);
            chk1 ("direct_addr_err", addr_err, mis);
            chk1 ("direct_wb_wreg",  wb_wreg, (sz == 0) ? wreg : 1'b0);
            chk32("direct_wb_wd",    wb_wd, (sz == 0) ? wd : 32'h0);
            chk32("direct_wb_wa",    {27'h0, wb_wa}, {27'h0, wa});
            chk1 ("direct_req",      dbus_req, 1'b0);
            chk1 ("direct_stall",    stall_req, 1'b0);
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            if (k > 0) @(negedge clk);
            dbus_gnt    = (k == gd);
            dbus_rvalid = (k == gd) ? 1'($urandom_range(0, 1)) : 1'b0;
            dbus_rdata  = $urandom;
            #1;
            chk1 ("req_req",   dbus_req, 1'b1);
            chk1 ("req_we",    dbus_we, st);
            chk32("req_addr",  dbus_addr, {wd[31:2], 2'b00});
            chk32("req_be",    {28'h0, dbus_be}, {28'h0, ref_be(sz, wd)});
            if (st) chk32("req_wdata", dbus_wdata, ref_wdata(sz, din));
            chk1 ("req_stall", stall_req, 1'b1);
        end
        for (int k = 0; k <= rd; k++) begin
            @(negedge clk);
            dbus_gnt    = 1'($urandom_range(0, 1));
            dbus_rvalid = (k == rd);
            dbus_rdata  = (k == rd) ? rdata : $urandom;
            #1;
            chk1("resp_req",   dbus_req, 1'b0);
            chk1("resp_stall", stall_req, k != rd);
        end
        @(negedge clk);
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = $urandom;
        #1;
        chk1 ("mem_wb_valid", wb_valid, 1'b1);
        chk1 ("mem_wb_wreg",  wb_wreg, !st);
        chk32("mem_wb_wd",    wb_wd, st ? 32'h0 : ref_load(op, wd, rdata));
        chk32("mem_wb_wa",    {27'h0, wb_wa}, {27'h0, wa});
        chk1 ("mem_addr_err", addr_err, 1'b0);
    endtask

    logic [7:0] op_tab [0:11] = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h94, 8'h98,
                                  8'h99, 8'h9A, 8'h10, 8'h95, 8'h97, 8'h9B};

    initial begin
        logic [7:0]  r_op;
        logic [31:0] r_addr;

        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk); #1;

        // non-memory pass-through
        do_op(8'h10, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0, 0, 0, 32'h0);
        idle_cycle();
        // LB at lane 3, sign extension
        do_op(8'h90, 1'b1, 1'b1, 5'd7, 32'h1003, 32'h0, 0, 0, 32'h8000_0000);
        idle_cycle();
        // SH at lane 2 with a 3-cycle grant delay
        do_op(8'h99, 1'b1, 1'b0, 5'd2, 32'h2002, 32'hABCD_1234, 3, 1, 32'h0);
        idle_cycle();
        // misaligned LW
        do_op(8'h94, 1'b1, 1'b1, 5'd9, 32'h3001, 32'h0, 0, 0, 32'h0);
        idle_cycle();
        // back-to-back: new op presented in the writeback cycle of the previous one
        do_op(8'h94, 1'b1, 1'b1, 5'd10, 32'h0000_0040, 32'h0, 1, 0, 32'hDEAD_BEEF);
        do_op(8'h93, 1'b1, 1'b1, 5'd11, 32'h0000_0042, 32'h0, 0, 2, 32'h8765_4321);
        do_op(8'h98, 1'b1, 1'b0, 5'd12, 32'h0000_0051, 32'h0000_00A5, 0, 0, 32'h0);
        idle_cycle();

        // reset while an LW waits in RESP
        in_valid = 1'b1; mem_aluop = 8'h94; mem_mreg = 1'b1; mem_wreg = 1'b1;
        mem_wa = 5'd3; mem_wd = 32'h500;
        #1;
        chk1("rst_accept_stall", stall_req, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; dbus_gnt = 1'b1;
        #1;
        chk1("rst_req", dbus_req, 1'b1);
        @(negedge clk);
        dbus_gnt = 1'b0;
        #1;
        chk1("rst_resp_stall", stall_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        dbus_rvalid = 1'b1; dbus_rdata = 32'h1111_2222;
        repeat (3) idle_cycle();

`ifdef MEM_TIMEOUT_EN
        in_valid = 1'b1; mem_aluop = 8'h94; mem_mreg = 1'b1; mem_wreg = 1'b1;
        mem_wa = 5'd4; mem_wd = 32'h600;
        #1;
        chk1("to_accept_stall", stall_req, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            in_valid = 1'b0; dbus_gnt = 1'b0;
            #1;
            chk1("to_req",   dbus_req, 1'b1);
            chk1("to_stall", stall_req, k < 16);
        end
        @(negedge clk); #1;
        chk1("to_req_drop",  dbus_req, 1'b0);
        chk1("to_wb_valid",  wb_valid, 1'b1);
        chk1("to_addr_err",  addr_err, 1'b1);
        chk1("to_wb_wreg",   wb_wreg, 1'b0);
        chk1("to_stall_rel", stall_req, 1'b0);
        idle_cycle();
`endif

        for (int i = 0; i < 120; i++) begin
            r_op   = op_tab[$urandom_range(0, 11)];
            r_addr = $urandom;
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            if ($urandom_range(0, 2) == 0) idle_cycle();
            do_op(r_op, ($urandom_range(0, 7) != 0), 1'($urandom), 5'($urandom), r_addr,
                  $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
